// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall, branch flush sequencing and data-memory freeze for the 5-stage RV32 pipeline.
// Optional HAZARD_PERF_CNT_EN macro adds stall/flush/load-use event counters.
module hazard_ctrl_unit #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       pipe_hold,
    output logic       instr_flush,
    output logic       ctrl_flush,
    output logic       mem_timeout,
    output logic [1:0] hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
    output logic [31:0] lu_events
`endif
);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2;
    localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    logic [1:0] r_state, w_next;
    logic [2:0] r_flush_cnt, w_flush_nxt;
    logic [7:0] r_wait_cnt, w_wait_inc;
    logic       r_timeout;
    logic       w_lu, w_busy, w_in_flush, w_stall, w_fl;

    assign w_lu = ex_mem_read & (ex_rd_addr != 5'd0) &
                  ((id_use_rs1 & (ex_rd_addr == id_rs1_addr)) | (id_use_rs2 & (ex_rd_addr == id_rs2_addr)));
    assign w_busy = dmem_req & ~dmem_ready;
    // Releasing from MEM_WAIT with flushes outstanding resumes the flush sequence in the same cycle.
    assign w_in_flush = (r_state == FLUSH) | ((r_state == MEM_WAIT) & (r_flush_cnt != 3'd0));
    assign w_stall = w_lu & ~ex_branch_taken & ~w_in_flush & ~w_busy;
    assign w_fl = ~w_busy & (ex_branch_taken | w_in_flush);
    assign w_wait_inc = (r_wait_cnt == TMO) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_flush_nxt;
            r_wait_cnt  <= (r_state == MEM_WAIT && w_busy) ? w_wait_inc : 8'd0;
            if (r_state == MEM_WAIT && w_busy && w_wait_inc == TMO)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next      = RUN;
        w_flush_nxt = r_flush_cnt;
        if (w_busy)
            w_next = MEM_WAIT;
        else if (ex_branch_taken) begin
            w_flush_nxt = PEN_M1;
            w_next      = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
        end else if (w_in_flush) begin
            w_flush_nxt = r_flush_cnt - 3'd1;
            w_next      = (r_flush_cnt == 3'd1) ? RUN : FLUSH;
        end
    end

    always_comb begin
        pc_write    = ~rst & ~w_busy & ~w_stall;
        ifid_write  = ~rst & ~w_busy & ~w_stall;
        pipe_hold   = ~rst & w_busy;
        instr_flush = ~rst & w_fl;
        ctrl_flush  = ~rst & (w_fl | w_stall);
        mem_timeout = r_timeout;
        hz_state    = r_state;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
            lu_events    <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(pipe_hold);
            flush_cycles <= flush_cycles + 32'(instr_flush);
            lu_events    <= lu_events + 32'(w_stall);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed stimulus with a queue-based scoreboard for hazard_ctrl_unit (BRANCH_PENALTY=2, MEM_TIMEOUT=8).
module tb_hazard_ctrl_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_mem_read = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [4:0] ex_rd_addr = '0, id_rs1_addr = '0, id_rs2_addr = '0;
    logic       ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_write, ifid_write, pipe_hold, instr_flush, ctrl_flush, mem_timeout;
    logic [1:0] hz_state;

    int n_checks = 0, n_pass = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    hazard_ctrl_unit #(.BRANCH_PENALTY(2), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .pipe_hold(pipe_hold),
        .instr_flush(instr_flush), .ctrl_flush(ctrl_flush),
        .mem_timeout(mem_timeout), .hz_state(hz_state)
    );

    always #5 clk = ~clk;

    // control: {rst, branch, dmem_req, dmem_ready}
    localparam logic [3:0] I = 4'b0000, R = 4'b1000, B = 4'b0100, W = 4'b0010, D = 4'b0011, BW = 4'b0110, BD = 4'b0111, RW = 4'b1010;
    // hazard operands: {mem_read, rd, rs1, rs2, use_rs1, use_rs2}
    localparam logic [17:0] H0    = 18'd0;
    localparam logic [17:0] LU1   = {1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0};
    localparam logic [17:0] LU2   = {1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1};
    localparam logic [17:0] LUX0  = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1};
    localparam logic [17:0] LUNO  = {1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0};
    // expected: {pc_write, ifid_write, pipe_hold, instr_flush, ctrl_flush, mem_timeout, hz_state}
    localparam logic [7:0] E_RST = 8'h00, E_NORM = 8'hC0, E_LU = 8'h08, E_BR = 8'hD8, E_FL = 8'hDA;
    localparam logic [7:0] E_HR = 8'h20, E_HW = 8'h21, E_HF = 8'h22, E_HWT = 8'h25;
    localparam logic [7:0] E_RELW = 8'hC1, E_RELF = 8'hD9, E_RELT = 8'hC5, E_NORMT = 8'hC4;

    task automatic step(input logic [3:0] c, input logic [17:0] h, input logic [7:0] e, input string n);
        @(posedge clk);
        #1;
        {rst, ex_branch_taken, dmem_req, dmem_ready} = c;
        {ex_mem_read, ex_rd_addr, id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2} = h;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [7:0] e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pc_write, ifid_write, pipe_hold, instr_flush, ctrl_flush, mem_timeout, hz_state};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %b want %b (pc,ifid,hold,iflush,cflush,tmo,state)", n, a, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(R, H0, E_RST, "reset");
        step(I, H0, E_NORM, "run_idle");
        step(I, LU1, E_LU, "lu_rs1");
        step(I, H0, E_NORM, "lu_release");
        step(I, LU2, E_LU, "lu_rs2");
        step(I, LUX0, E_NORM, "lu_x0");
        step(I, LUNO, E_NORM, "lu_nouse");
        step(B, H0, E_BR, "br_run");
        step(I, H0, E_FL, "br_flush");
        step(I, H0, E_NORM, "br_done");
        step(B, LU1, E_BR, "br_beats_lu");
        step(I, LU1, E_FL, "flush_ignores_lu");
        step(I, H0, E_NORM, "after_br_lu");
        step(B, H0, E_BR, "br_again");
        step(B, H0, E_FL, "flush_reload");
        step(I, H0, E_FL, "flush_after_reload");
        step(I, H0, E_NORM, "reload_done");
        step(W, H0, E_HR, "mw_1");
        step(W, H0, E_HW, "mw_2");
        step(W, H0, E_HW, "mw_3");
        step(W, H0, E_HW, "mw_4");
        step(D, H0, E_RELW, "mw_release");
        step(I, H0, E_NORM, "mw_after");
        step(B, H0, E_BR, "il_br");
        step(W, H0, E_HF, "il_hold_1");
        step(W, H0, E_HW, "il_hold_2");
        step(W, H0, E_HW, "il_hold_3");
        step(I, H0, E_RELF, "il_last_flush");
        step(I, H0, E_NORM, "il_run");
        step(BW, H0, E_HR, "busy_beats_br");
        step(BD, H0, E_RELF, "br_on_release");
        step(I, H0, E_FL, "br_on_release_flush");
        step(I, H0, E_NORM, "br_on_release_done");
        step(W, H0, E_HR, "to_run");
        for (int k = 1; k <= 11; k++)
            step(W, H0, (k <= 8) ? E_HW : E_HWT, $sformatf("to_wait_%0d", k));
        step(D, H0, E_RELT, "to_release_sticky");
        step(I, H0, E_NORMT, "to_sticky_run");
        step(R, H0, E_RST, "to_rst");
        step(I, H0, E_NORM, "to_cleared");
        step(W, H0, E_HR, "ar_busy");
        step(W, H0, E_HW, "ar_wait");
        step(RW, H0, E_RST, "ar_async");
        step(I, H0, E_NORM, "ar_after");
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard and flush controller for the 5-stage RV32 core.
- Produces the CtrlSignalFlush / IRWrite-style controls that the ID/EXE pipeline register consumes, plus PC and IF/ID write enables and instruction flush.
- Detects load-use hazards against the EX-stage load and drives branch-flush sequencing.
- Freezes the whole pipeline on a data-memory wait handshake, with a timeout error flag.

Parameters:
- BRANCH_PENALTY, 2, number of consecutive flush cycles issued per taken branch/jump (legal range 1-7).
- MEM_TIMEOUT, 255, MEM_WAIT cycle count at which mem_timeout is raised (8-bit, 1-255).

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ex_mem_read  input  1  EX-stage instruction is a load (ID_MemRead from ID/EXE register)
- ex_rd_addr  input  5  EX-stage destination register
- id_rs1_addr  input  5  decode-stage rs1 address
- id_rs2_addr  input  5  decode-stage rs2 address
- id_use_rs1  input  1  decode instruction reads rs1
- id_use_rs2  input  1  decode instruction reads rs2
- ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle
- dmem_req  input  1  MEM-stage data access pending
- dmem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID register write enable
- pipe_hold  output  1  freeze ID/EXE, EX/MEM, MEM/WB registers
- instr_flush  output  1  replace IF/ID contents with NOP
- ctrl_flush  output  1  CtrlSignalFlush to ID/EXE (zero MemWrite/MemRead/RegWrite/Branch/IRWrite)
- mem_timeout  output  1  sticky memory-timeout error
- hz_state  output  2  current FSM state (debug)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0. While rst=1, all outputs are 0 except hz_state=RUN (2'd0).
- Combinational terms:
  - lu = ex_mem_read & (ex_rd_addr!=0) & ((id_use_rs1 & ex_rd_addr==id_rs1_addr) | (id_use_rs2 & ex_rd_addr==id_rs2_addr)).
  - mem_busy = dmem_req & ~dmem_ready.
- Priority each cycle: mem_busy > ex_branch_taken > lu > normal.
- States: RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is illegal and goes to RUN.
- Outputs are combinational from state and inputs; state and counters are registered.
- Freeze action (any state, mem_busy=1):
  - pc_write=0, ifid_write=0, pipe_hold=1, flushes=0.
  - Next state MEM_WAIT; flush_cnt is preserved.
- RUN:
  - Branch: pc_write=1, ifid_write=1, instr_flush=1, ctrl_flush=1. If BRANCH_PENALTY>1, go to FLUSH with flush_cnt=BRANCH_PENALTY-1; else stay in RUN.
  - Load-use: pc_write=0, ifid_write=0, ctrl_flush=1, instr_flush=0. Stay in RUN; exactly one bubble, since the hazard clears once the load advances.
  - Normal: pc_write=1, ifid_write=1, others 0.
- MEM_WAIT:
  - wait_cnt increments each cycle in this state, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set the following cycle and holds until rst. The freeze persists.
  - On dmem_ready=1, outputs follow the RUN/FLUSH rules for the current inputs. Next state is FLUSH if flush_cnt!=0, else RUN. wait_cnt clears.
- FLUSH:
  - pc_write=1, ifid_write=1, instr_flush=1, ctrl_flush=1; lu is ignored.
  - flush_cnt decrements; go to RUN when it reaches 0.
  - A new ex_branch_taken in FLUSH reloads flush_cnt=BRANCH_PENALTY-1.
- Simultaneous branch and load-use: branch wins (the load-use instruction is flushed anyway).
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts immediately: outputs go to reset values asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds three outputs, stall_cycles [31:0], flush_cycles [31:0] and lu_events [31:0]. Each is reset to 0, increments on cycles with pipe_hold=1, instr_flush=1, and load-use bubble respectively, and wraps at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_use_rs1=1 for 1 cycle -> pc_write=0, ifid_write=0, ctrl_flush=1 for exactly 1 cycle, then pc_write=1. Repeating with ex_rd_addr=0 -> no stall.
- Branch with BRANCH_PENALTY=2: ex_branch_taken pulse -> instr_flush=ctrl_flush=1 for 2 cycles, hz_state RUN->FLUSH->RUN.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then ready=1 -> pipe_hold=1 and pc_write=0 for 4 cycles, release on cycle 5, no mem_timeout.
- Timeout with MEM_TIMEOUT=8: dmem_req=1, ready held 0 for 12 cycles -> mem_timeout rises after 8 cycles in MEM_WAIT and stays 1 after ready; cleared only by rst.
- Interleave: taken branch, then mem_busy during FLUSH cycle 1 for 3 cycles -> freeze 3 cycles, then remaining 1 flush cycle, then RUN.
- Async reset in MEM_WAIT -> all outputs 0 immediately without a clock edge; hz_state=0 after release. With HAZARD_PERF_CNT_EN, counters read 0.
